// File: rtl/ctrl_pipe_if.sv
// Interface between the ID-stage decoder and the pipeline control/hazard unit.
// Carries decoder controls in and the per-stage controls, forwarding selects and hazard flags out.
interface ctrl_pipe_if #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALUOP_W = 2
);
  logic               id_valid;
  logic               id_regDst;
  logic               id_branch;
  logic               id_LeMem;
  logic               id_memParaReg;
  logic [ALUOP_W-1:0] id_aluOp;
  logic               id_EscreveMem;
  logic               id_OrigAlu;
  logic               id_EscreveReg;
  logic [REG_AW-1:0]  id_rs;
  logic [REG_AW-1:0]  id_rt;
  logic [REG_AW-1:0]  id_rd;
  logic               ex_zero;

  logic               ex_regDst;
  logic               ex_OrigAlu;
  logic [ALUOP_W-1:0] ex_aluOp;
  logic [REG_AW-1:0]  ex_rs;
  logic [REG_AW-1:0]  ex_rt;
  logic [1:0]         fwd_a;
  logic [1:0]         fwd_b;
  logic               mem_LeMem;
  logic               mem_EscreveMem;
  logic               pc_src;
  logic               wb_memParaReg;
  logic               wb_EscreveReg;
  logic [REG_AW-1:0]  wb_dest;
  logic               stall;
  logic               flush;

  modport master (
    output id_valid, id_regDst, id_branch, id_LeMem, id_memParaReg, id_aluOp,
           id_EscreveMem, id_OrigAlu, id_EscreveReg, id_rs, id_rt, id_rd, ex_zero,
    input  ex_regDst, ex_OrigAlu, ex_aluOp, ex_rs, ex_rt, fwd_a, fwd_b,
           mem_LeMem, mem_EscreveMem, pc_src, wb_memParaReg, wb_EscreveReg,
           wb_dest, stall, flush
  );

  modport slave (
    input  id_valid, id_regDst, id_branch, id_LeMem, id_memParaReg, id_aluOp,
           id_EscreveMem, id_OrigAlu, id_EscreveReg, id_rs, id_rt, id_rd, ex_zero,
    output ex_regDst, ex_OrigAlu, ex_aluOp, ex_rs, ex_rt, fwd_a, fwd_b,
           mem_LeMem, mem_EscreveMem, pc_src, wb_memParaReg, wb_EscreveReg,
           wb_dest, stall, flush
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Control carrier and hazard unit for the 5-stage MIPS core: ID/EX, EX/MEM, MEM/WB
// control registers, load-use stall, beq resolution in MEM with flush, and EX forwarding.
module ctrl_pipe #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALUOP_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  ctrl_pipe_if.slave bus
);

  typedef struct packed {
    logic               valid;
    logic               regDst;
    logic               branch;
    logic               LeMem;
    logic               memParaReg;
    logic [ALUOP_W-1:0] aluOp;
    logic               EscreveMem;
    logic               OrigAlu;
    logic               EscreveReg;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  dest;
  } idex_t;

  typedef struct packed {
    logic              valid;
    logic              branch;
    logic              LeMem;
    logic              memParaReg;
    logic              EscreveMem;
    logic              EscreveReg;
    logic [REG_AW-1:0] dest;
    logic              zero;
  } exmem_t;

  typedef struct packed {
    logic              memParaReg;
    logic              EscreveReg;
    logic [REG_AW-1:0] dest;
  } memwb_t;

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  logic load_use_c;
  logic pc_src_c;
  logic stall_c;

  // Most recent producer wins; register 0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input exmem_t m, input memwb_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (m.EscreveReg && (m.dest != '0) && (m.dest == src)) begin
      sel = 2'b10;
    end else if (w.EscreveReg && (w.dest != '0) && (w.dest == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    load_use_c = idex_q.valid && idex_q.LeMem && (idex_q.dest != '0) &&
                 ((idex_q.dest == bus.id_rs) || (idex_q.dest == bus.id_rt)) &&
                 bus.id_valid;
    pc_src_c   = exmem_q.valid && exmem_q.branch && exmem_q.zero;
    // A taken branch squashes the stalled instruction, so the stall is moot.
    stall_c    = load_use_c && !pc_src_c;

    idex_d = '0;
    if (!pc_src_c && !stall_c && bus.id_valid) begin
      idex_d.valid      = 1'b1;
      idex_d.regDst     = bus.id_regDst;
      idex_d.branch     = bus.id_branch;
      idex_d.LeMem      = bus.id_LeMem;
      idex_d.memParaReg = bus.id_memParaReg;
      idex_d.aluOp      = bus.id_aluOp;
      idex_d.EscreveMem = bus.id_EscreveMem;
      idex_d.OrigAlu    = bus.id_OrigAlu;
      idex_d.EscreveReg = bus.id_EscreveReg;
      idex_d.rs         = bus.id_rs;
      idex_d.rt         = bus.id_rt;
      idex_d.dest       = bus.id_regDst ? bus.id_rd : bus.id_rt;
    end

    exmem_d = '0;
    if (!pc_src_c) begin
      exmem_d.valid      = idex_q.valid;
      exmem_d.branch     = idex_q.branch;
      exmem_d.LeMem      = idex_q.LeMem;
      exmem_d.memParaReg = idex_q.memParaReg;
      exmem_d.EscreveMem = idex_q.EscreveMem;
      exmem_d.EscreveReg = idex_q.EscreveReg;
      exmem_d.dest       = idex_q.dest;
      exmem_d.zero       = bus.ex_zero;
    end

    memwb_d            = '0;
    memwb_d.memParaReg = exmem_q.memParaReg;
    memwb_d.EscreveReg = exmem_q.EscreveReg;
    memwb_d.dest       = exmem_q.dest;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign bus.ex_regDst      = idex_q.regDst;
  assign bus.ex_OrigAlu     = idex_q.OrigAlu;
  assign bus.ex_aluOp       = idex_q.aluOp;
  assign bus.ex_rs          = idex_q.rs;
  assign bus.ex_rt          = idex_q.rt;
  assign bus.fwd_a          = fwd_sel(idex_q.rs, exmem_q, memwb_q);
  assign bus.fwd_b          = fwd_sel(idex_q.rt, exmem_q, memwb_q);
  assign bus.mem_LeMem      = exmem_q.LeMem;
  assign bus.mem_EscreveMem = exmem_q.EscreveMem;
  assign bus.pc_src         = pc_src_c;
  assign bus.wb_memParaReg  = memwb_q.memParaReg;
  assign bus.wb_EscreveReg  = memwb_q.EscreveReg;
  assign bus.wb_dest        = memwb_q.dest;
  assign bus.stall          = stall_c;
  assign bus.flush          = pc_src_c;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Cycle-by-cycle vector bench for ctrl_pipe: each record gives the ID inputs for a cycle and
// the outputs expected during that cycle, given all earlier records.
module tb_ctrl_pipe;

  typedef struct packed {
    logic       v;
    logic       regDst;
    logic       branch;
    logic       LeMem;
    logic       memParaReg;
    logic [1:0] aluOp;
    logic       EscreveMem;
    logic       OrigAlu;
    logic       EscreveReg;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } in_t;

  typedef struct packed {
    logic       ex_regDst;
    logic       ex_OrigAlu;
    logic [1:0] ex_aluOp;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       mem_LeMem;
    logic       mem_EscreveMem;
    logic       pc_src;
    logic       wb_memParaReg;
    logic       wb_EscreveReg;
    logic [4:0] wb_dest;
    logic       stall;
    logic       flush;
  } exp_t;

  typedef struct {
    logic rst;
    in_t  id;
    logic zero;
    exp_t e;
    exp_t care;
    logic chk;
  } vec_t;

  typedef struct {
    exp_t e;
    exp_t care;
    int   tag;
  } sb_t;

  localparam exp_t Z        = '0;
  localparam exp_t CARE_ALL = '1;
  // Bubble contents are don't-care: addresses in EX (and the selects they drive), or wb_dest.
  localparam exp_t CARE_EX  = exp_t'{ex_rs: '0, ex_rt: '0, fwd_a: '0, fwd_b: '0, default: '1};
  localparam exp_t CARE_WB  = exp_t'{wb_dest: '0, default: '1};

  logic clk;
  logic rst;
  ctrl_pipe_if #(.REG_AW(5), .ALUOP_W(2)) bus ();

  ctrl_pipe #(.REG_AW(5), .ALUOP_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   tag    = 0;

  function automatic in_t nop();
    return '0;
  endfunction

  function automatic in_t rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return in_t'{v: 1'b1, regDst: 1'b1, aluOp: 2'b10, EscreveReg: 1'b1,
                 rs: rs, rt: rt, rd: rd, default: '0};
  endfunction

  function automatic in_t lw(input logic [4:0] rs, input logic [4:0] rt);
    return in_t'{v: 1'b1, LeMem: 1'b1, memParaReg: 1'b1, OrigAlu: 1'b1, EscreveReg: 1'b1,
                 rs: rs, rt: rt, default: '0};
  endfunction

  function automatic in_t sw(input logic [4:0] rs, input logic [4:0] rt);
    return in_t'{v: 1'b1, EscreveMem: 1'b1, OrigAlu: 1'b1, rs: rs, rt: rt, default: '0};
  endfunction

  function automatic in_t beq(input logic [4:0] rs, input logic [4:0] rt);
    return in_t'{v: 1'b1, branch: 1'b1, aluOp: 2'b01, rs: rs, rt: rt, default: '0};
  endfunction

  function automatic void row(input in_t i, input logic z, input exp_t e, input exp_t c);
    vecs.push_back('{rst: 1'b0, id: i, zero: z, e: e, care: c, chk: 1'b1});
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a.ex_regDst      = bus.ex_regDst;
    a.ex_OrigAlu     = bus.ex_OrigAlu;
    a.ex_aluOp       = bus.ex_aluOp;
    a.ex_rs          = bus.ex_rs;
    a.ex_rt          = bus.ex_rt;
    a.fwd_a          = bus.fwd_a;
    a.fwd_b          = bus.fwd_b;
    a.mem_LeMem      = bus.mem_LeMem;
    a.mem_EscreveMem = bus.mem_EscreveMem;
    a.pc_src         = bus.pc_src;
    a.wb_memParaReg  = bus.wb_memParaReg;
    a.wb_EscreveReg  = bus.wb_EscreveReg;
    a.wb_dest        = bus.wb_dest;
    a.stall          = bus.stall;
    a.flush          = bus.flush;
    return a;
  endfunction

  // Drive one cycle, queue what it should show, then sample just before the next rising edge.
  task automatic step(input logic r, input in_t i, input logic z, input exp_t e,
                      input exp_t care, input logic chk);
    sb_t  s;
    exp_t a;
    @(negedge clk);
    rst               = r;
    bus.id_valid      = i.v;
    bus.id_regDst     = i.regDst;
    bus.id_branch     = i.branch;
    bus.id_LeMem      = i.LeMem;
    bus.id_memParaReg = i.memParaReg;
    bus.id_aluOp      = i.aluOp;
    bus.id_EscreveMem = i.EscreveMem;
    bus.id_OrigAlu    = i.OrigAlu;
    bus.id_EscreveReg = i.EscreveReg;
    bus.id_rs         = i.rs;
    bus.id_rt         = i.rt;
    bus.id_rd         = i.rd;
    bus.ex_zero       = z;
    if (chk) begin
      sb.push_back('{e: e, care: care, tag: tag});
      tag++;
    end
    #4;
    if (chk) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL scoreboard: no expected entry queued (got %h)", actual());
      end else begin
        s = sb.pop_front();
        a = actual();
        if (((a ^ s.e) & s.care) !== '0) begin
          n_miss++;
          $display("FAIL vec %0d: got %h expected %h (care mask %h)", s.tag, a, s.e, s.care);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.id_valid = 1'b0; bus.id_regDst = 1'b0; bus.id_branch = 1'b0; bus.id_LeMem = 1'b0;
    bus.id_memParaReg = 1'b0; bus.id_aluOp = '0; bus.id_EscreveMem = 1'b0;
    bus.id_OrigAlu = 1'b0; bus.id_EscreveReg = 1'b0; bus.id_rs = '0; bus.id_rt = '0;
    bus.id_rd = '0; bus.ex_zero = 1'b0;

    vecs.push_back('{rst: 1'b1, id: nop(), zero: 1'b0, e: Z, care: CARE_ALL, chk: 1'b0});
    row(nop(), 0, Z, CARE_ALL);
    // R-type carried through every stage
    row(rtype(1, 2, 3), 0, Z, CARE_ALL);
    row(nop(), 0, exp_t'{ex_regDst: 1, ex_aluOp: 2, ex_rs: 1, ex_rt: 2, default: '0}, CARE_ALL);
    row(nop(), 0, Z, CARE_ALL);
    row(nop(), 0, exp_t'{wb_EscreveReg: 1, wb_dest: 3, default: '0}, CARE_ALL);
    row(nop(), 0, Z, CARE_ALL);
    // lw $5 then dependent add on rs: one bubble, then MEM/WB forward
    row(lw(0, 5), 0, Z, CARE_ALL);
    row(rtype(5, 6, 7), 0, exp_t'{ex_OrigAlu: 1, ex_rt: 5, stall: 1, default: '0}, CARE_ALL);
    row(rtype(5, 6, 7), 0, exp_t'{mem_LeMem: 1, default: '0}, CARE_EX);
    row(nop(), 0, exp_t'{ex_regDst: 1, ex_aluOp: 2, ex_rs: 5, ex_rt: 6, fwd_a: 2'b01,
                         wb_memParaReg: 1, wb_EscreveReg: 1, wb_dest: 5, default: '0}, CARE_ALL);
    row(nop(), 0, Z, CARE_ALL);
    row(nop(), 0, exp_t'{wb_EscreveReg: 1, wb_dest: 7, default: '0}, CARE_ALL);
    row(nop(), 0, Z, CARE_ALL);
    // add $3 then sub using $3 twice: EX/MEM forward on both operands
    row(rtype(1, 2, 3), 0, Z, CARE_ALL);
    row(rtype(3, 3, 4), 0, exp_t'{ex_regDst: 1, ex_aluOp: 2, ex_rs: 1, ex_rt: 2, default: '0}, CARE_ALL);
    row(nop(), 0, exp_t'{ex_regDst: 1, ex_aluOp: 2, ex_rs: 3, ex_rt: 3, fwd_a: 2'b10, fwd_b: 2'b10,
                         default: '0}, CARE_ALL);
    row(nop(), 0, exp_t'{wb_EscreveReg: 1, wb_dest: 3, default: '0}, CARE_ALL);
    row(nop(), 0, exp_t'{wb_EscreveReg: 1, wb_dest: 4, default: '0}, CARE_ALL);
    row(nop(), 0, Z, CARE_ALL);
    // same chain through $0: never forwarded
    row(rtype(1, 2, 0), 0, Z, CARE_ALL);
    row(rtype(0, 0, 4), 0, exp_t'{ex_regDst: 1, ex_aluOp: 2, ex_rs: 1, ex_rt: 2, default: '0}, CARE_ALL);
    row(nop(), 0, exp_t'{ex_regDst: 1, ex_aluOp: 2, default: '0}, CARE_ALL);
    row(nop(), 0, exp_t'{wb_EscreveReg: 1, default: '0}, CARE_ALL);
    row(nop(), 0, exp_t'{wb_EscreveReg: 1, wb_dest: 4, default: '0}, CARE_ALL);
    row(nop(), 0, Z, CARE_ALL);
    // two producers of $3 in flight: EX/MEM beats MEM/WB
    row(rtype(1, 2, 3), 0, Z, CARE_ALL);
    row(rtype(1, 2, 3), 0, exp_t'{ex_regDst: 1, ex_aluOp: 2, ex_rs: 1, ex_rt: 2, default: '0}, CARE_ALL);
    row(rtype(3, 0, 5), 0, exp_t'{ex_regDst: 1, ex_aluOp: 2, ex_rs: 1, ex_rt: 2, default: '0}, CARE_ALL);
    row(nop(), 0, exp_t'{ex_regDst: 1, ex_aluOp: 2, ex_rs: 3, fwd_a: 2'b10,
                         wb_EscreveReg: 1, wb_dest: 3, default: '0}, CARE_ALL);
    row(nop(), 0, exp_t'{wb_EscreveReg: 1, wb_dest: 3, default: '0}, CARE_ALL);
    row(nop(), 0, exp_t'{wb_EscreveReg: 1, wb_dest: 5, default: '0}, CARE_ALL);
    row(nop(), 0, Z, CARE_ALL);
    // taken beq squashes the sw and the R-type behind it
    row(beq(1, 2), 0, Z, CARE_ALL);
    row(sw(1, 2), 1, exp_t'{ex_aluOp: 1, ex_rs: 1, ex_rt: 2, default: '0}, CARE_ALL);
    row(rtype(1, 2, 7), 0, exp_t'{ex_OrigAlu: 1, ex_rs: 1, ex_rt: 2, pc_src: 1, flush: 1,
                                  default: '0}, CARE_ALL);
    row(nop(), 0, exp_t'{wb_dest: 2, default: '0}, CARE_EX);
    row(nop(), 0, Z, CARE_WB);
    row(nop(), 0, Z, CARE_ALL);
    // not-taken beq: sw proceeds
    row(beq(1, 2), 0, Z, CARE_ALL);
    row(sw(1, 2), 0, exp_t'{ex_aluOp: 1, ex_rs: 1, ex_rt: 2, default: '0}, CARE_ALL);
    row(nop(), 0, exp_t'{ex_OrigAlu: 1, ex_rs: 1, ex_rt: 2, default: '0}, CARE_ALL);
    row(nop(), 0, exp_t'{mem_EscreveMem: 1, wb_dest: 2, default: '0}, CARE_ALL);
    row(nop(), 0, exp_t'{wb_dest: 2, default: '0}, CARE_ALL);
    row(nop(), 0, Z, CARE_ALL);
    // invalid opcode with live-looking controls enters as a bubble
    row(in_t'{v: 1'b0, regDst: 1'b1, aluOp: 2'b10, EscreveReg: 1'b1, rs: 1, rt: 2, rd: 3,
              default: '0}, 0, Z, CARE_ALL);
    row(nop(), 0, Z, CARE_EX);
    row(nop(), 0, Z, CARE_ALL);
    row(nop(), 0, Z, CARE_WB);
    // load-use through rt, then MEM/WB forward on operand B
    row(lw(0, 5), 0, Z, CARE_ALL);
    row(rtype(1, 5, 8), 0, exp_t'{ex_OrigAlu: 1, ex_rt: 5, stall: 1, default: '0}, CARE_ALL);
    row(rtype(1, 5, 8), 0, exp_t'{mem_LeMem: 1, default: '0}, CARE_EX);
    row(nop(), 0, exp_t'{ex_regDst: 1, ex_aluOp: 2, ex_rs: 1, ex_rt: 5, fwd_b: 2'b01,
                         wb_memParaReg: 1, wb_EscreveReg: 1, wb_dest: 5, default: '0}, CARE_ALL);
    row(nop(), 0, Z, CARE_WB);
    row(nop(), 0, exp_t'{wb_EscreveReg: 1, wb_dest: 8, default: '0}, CARE_ALL);
    row(nop(), 0, Z, CARE_ALL);
    // lw into $0 never stalls
    row(lw(0, 0), 0, Z, CARE_ALL);
    row(rtype(0, 0, 9), 0, exp_t'{ex_OrigAlu: 1, default: '0}, CARE_ALL);
    row(nop(), 0, exp_t'{ex_regDst: 1, ex_aluOp: 2, mem_LeMem: 1, default: '0}, CARE_ALL);
    row(nop(), 0, exp_t'{wb_memParaReg: 1, wb_EscreveReg: 1, default: '0}, CARE_ALL);
    row(nop(), 0, exp_t'{wb_EscreveReg: 1, wb_dest: 9, default: '0}, CARE_ALL);
    row(nop(), 0, Z, CARE_ALL);

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].rst, vecs[k].id, vecs[k].zero, vecs[k].e, vecs[k].care, vecs[k].chk);
    end

    // Flush coinciding with a load-use: flush wins and both lw and add are squashed
    step(0, beq(1, 2), 0, Z, CARE_ALL, 1);
    step(0, lw(0, 5), 1, exp_t'{ex_aluOp: 1, ex_rs: 1, ex_rt: 2, default: '0}, CARE_ALL, 1);
    step(0, rtype(5, 6, 7), 0, exp_t'{ex_OrigAlu: 1, ex_rt: 5, pc_src: 1, flush: 1, default: '0},
         CARE_ALL, 1);
    step(0, nop(), 0, exp_t'{wb_dest: 2, default: '0}, CARE_EX, 1);
    step(0, nop(), 0, Z, CARE_WB, 1);
    step(0, nop(), 0, Z, CARE_ALL, 1);

    // Reset while a lw is in MEM and a second lw is stalling a dependent add
    step(0, lw(0, 5), 0, Z, CARE_ALL, 1);
    step(0, lw(0, 6), 0, exp_t'{ex_OrigAlu: 1, ex_rt: 5, default: '0}, CARE_ALL, 1);
    step(1, rtype(6, 5, 7), 0, exp_t'{ex_OrigAlu: 1, ex_rt: 6, mem_LeMem: 1, stall: 1,
                                      default: '0}, CARE_ALL, 1);
    step(0, rtype(6, 5, 7), 0, Z, CARE_ALL, 1);
    step(0, nop(), 0, exp_t'{ex_regDst: 1, ex_aluOp: 2, ex_rs: 6, ex_rt: 5, default: '0}, CARE_ALL, 1);
    step(0, nop(), 0, Z, CARE_ALL, 1);
    step(0, nop(), 0, exp_t'{wb_EscreveReg: 1, wb_dest: 7, default: '0}, CARE_ALL, 1);
    step(0, nop(), 0, Z, CARE_ALL, 1);

    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
Pipeline control carrier and hazard unit for the 5-stage MIPS core. It takes the decoded control word from the main decoder in ID and registers it through ID/EX, EX/MEM and MEM/WB, delivering each stage only the signals that stage consumes. It detects load-use hazards and stalls ID, resolves beq in MEM and flushes younger stages, and generates EX-stage operand forwarding selects.

Parameters:
REG_AW, 5, register-address width
ALUOP_W, 2, width of the aluOp control field

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction; 0 means insert a bubble
id_regDst  in  1  decoder control: rd is the destination, not rt
id_branch  in  1  decoder control: beq
id_LeMem  in  1  decoder control: memory read (lw)
id_memParaReg  in  1  decoder control: writeback data comes from memory
id_aluOp  in  ALUOP_W  decoder control: ALU operation class
id_EscreveMem  in  1  decoder control: memory write (sw)
id_OrigAlu  in  1  decoder control: ALU B operand is the immediate
id_EscreveReg  in  1  decoder control: register write
id_rs, id_rt, id_rd  in  REG_AW  register fields of the ID instruction
ex_zero  in  1  ALU zero flag, valid during EX
ex_regDst, ex_OrigAlu  out  1  EX-stage controls
ex_aluOp  out  ALUOP_W  EX-stage control
ex_rs, ex_rt  out  REG_AW  EX-stage operand addresses
fwd_a, fwd_b  out  2  forwarding select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result
mem_LeMem, mem_EscreveMem  out  1  MEM-stage controls
pc_src  out  1  branch taken; select the branch target
wb_memParaReg, wb_EscreveReg  out  1  WB-stage controls
wb_dest  out  REG_AW  WB destination register
stall  out  1  hold PC and IF/ID this cycle
flush  out  1  clear IF/ID this cycle

Behaviour:
- Reset, when rst is high at a clock edge:
  - Every stage register clears: valid=0, all control bits 0, aluOp 0, all addresses 0, stored zero flag 0.
  - All outputs read 0 on the following cycle.
  - rst has priority over every other input, including mid-stall and mid-flush.
- Bubble:
  - Sets every control bit and aluOp to 0 and valid to 0.
  - Addresses in a bubble are don't-care and must not trigger forwarding or hazards, because the write enables are 0.
- Destination:
  - Computed at the ID/EX capture: dest = regDst ? rd : rt.
  - Carried down with the control bits to EX/MEM and MEM/WB.
- Stage advance on each edge, without a flush:
  - ID/EX <= stall or !id_valid ? bubble : ID controls.
  - EX/MEM <= ID/EX, plus ex_zero captured as mem_zero.
  - MEM/WB <= EX/MEM (memParaReg, EscreveReg, dest).
- Load-use stall, combinational:
  - stall = ex_valid & ex_LeMem & (ex_dest != 0) & ((ex_dest == id_rs) | (ex_dest == id_rt)) & id_valid.
  - The rt compare is unconditional; this is deliberately conservative.
  - Exactly one bubble is inserted per lw and dependent pair.
- Branch, combinational:
  - pc_src = mem_valid & mem_branch & mem_zero.
  - flush = pc_src.
  - When flush is 1, the next edge loads bubbles into both ID/EX and EX/MEM.
  - Result: the 3 younger instructions are squashed (IF/ID is cleared upstream).
- Simultaneous flush and stall:
  - Flush wins; stall is forced to 0 while flush is 1.
  - The stalled instruction is itself squashed.
- Forwarding, combinational from registered state; fwd_b uses ex_rt instead of ex_rs:
  - 10 if mem_EscreveReg & mem_dest != 0 & mem_dest == ex_rs.
  - Otherwise 01 if wb_EscreveReg & wb_dest != 0 & wb_dest == ex_rs.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB (most recent producer wins).
  - Register 0 is never forwarded.
- Unknown opcodes: the decoder drives id_valid=0, and the instruction enters the pipe as a bubble.
- Latency: a control bit presented in ID appears on the ex_ outputs after 1 edge, the mem_ outputs after 2, and the wb_ outputs after 3.

Test Plan:
1. Reset, then an R-type (id_rs=1, id_rt=2, id_rd=3, regDst=1, EscreveReg=1, aluOp=10) with id_valid=1 -> ex_aluOp=10 after 1 edge, wb_EscreveReg=1 and wb_dest=3 after 3 edges; stall=0 and flush=0 throughout.
2. lw $5 (rt=5, LeMem=1), then add with rs=5 -> stall=1 for exactly one cycle; ID/EX holds a bubble; the next cycle shows fwd_a=01 for the add.
3. add $3, then sub using rs=3 and rt=3 in back-to-back cycles -> fwd_a=10 and fwd_b=10. Same chain with dest $0 -> fwd_a=00 and fwd_b=00.
4. beq with ex_zero=1 while in EX -> pc_src=1 and flush=1 one cycle later. The next edge clears ex_ and mem_ controls: mem_EscreveMem=0 even if an sw was behind the branch. With ex_zero=0 -> no flush.
5. Flush cycle coinciding with a load-use condition -> stall=0, flush=1, and both instructions are squashed.
6. Assert rst while a lw is in MEM and a stall is active -> all outputs 0 on the next cycle; no stale writeback occurs afterwards.
